dmem_responder: RTL and testbench

- Responder end of the datapath's data-memory interface. It accepts read and write requests from the datapath and services them from an on-chip word array after a parameterised number of wait states.
- Signals completion with a one-cycle ready pulse. The datapath holds its request and stalls until that pulse arrives.
- Flags misaligned, out-of-range and conflicting requests with an error pulse instead of performing the access.

---
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with fixed wait states, one-cycle ready pulse and error flagging
module dmem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_2000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        mem_err
);
   localparam int          IW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, err_q, err_d;
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] offset;
   logic [IW-1:0] idx;
   logic        bad, we;

   // Decode the latched request; the 32-bit subtraction wraps for addresses below the base,
   // so the explicit lower-bound compare is what rejects those
   assign offset = addr_q - ADDR_BASE;
   assign idx    = offset[IW+1:2];
   assign bad    = (rd_q & wr_q) | (addr_q[1:0] != 2'b00) | (addr_q < ADDR_BASE) | (offset >= SPAN);
   assign we     = (state_q == WAIT) && (cnt_q == 4'd0) && wr_q && !bad;

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;
   assign mem_err   = err_q;

   // Next-state and output logic: accept in IDLE, count down in WAIT, complete on the zero count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (mem_rd | mem_wr) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            rd_d    = mem_rd;
            wr_d    = mem_wr;
            cnt_d   = 4'(LATENCY);
            state_d = WAIT;
         end
         WAIT: if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
         end else begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = bad;
            rdata_d = (rd_q && !bad) ? mem_q[idx] : rdata_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset abandons any pending access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Word array keeps its contents across reset; written only on a good write completion
   always_ff @(posedge clk) begin
      if (we) mem_q[idx] <= wdata_q;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven transactions checked through an expected-result queue
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_rd = 1'b0, mem_wr = 1'b0;
   logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
   logic [31:0] mem_rdata;
   logic        mem_ready, mem_err;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   checks = 0;
   int   errors = 0;

   dmem_responder #(.ADDR_BASE(32'h2000), .DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!mem_ready && n < 20);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
         e = sb.pop_front();
         check({e.name, "_err"}, 32'(mem_err), 32'(e.err));
         check({e.name, "_rdata"}, mem_rdata, e.rdata);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int n;
      @(negedge clk);
      mem_rd = v.rd;
      mem_wr = v.wr;
      mem_addr = v.addr;
      mem_wdata = v.wdata;
      sb.push_back('{v.name, v.err, v.rdata});
      @(posedge clk);
      wait_ready(n);
      check({v.name, "_latency"}, 32'(n), 32'd3);
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      pop_check();
      @(posedge clk);
      #1;
      check({v.name, "_ready_fall"}, 32'(mem_ready), 32'd0);
      check({v.name, "_err_fall"}, 32'(mem_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   n2;
      logic seen;
      logic prev;
      logic consec;
      vecs[0]  = '{"wr_2004",    1'b0, 1'b1, 32'h2004, 32'hCAFEF00D, 1'b0, 32'h00000000};
      vecs[1]  = '{"rd_2004",    1'b1, 1'b0, 32'h2004, 32'h0,        1'b0, 32'hCAFEF00D};
      vecs[2]  = '{"rd_misalign",1'b1, 1'b0, 32'h2006, 32'h0,        1'b1, 32'hCAFEF00D};
      vecs[3]  = '{"wr_2000",    1'b0, 1'b1, 32'h2000, 32'h0BADBEEF, 1'b0, 32'hCAFEF00D};
      vecs[4]  = '{"wr_23fc",    1'b0, 1'b1, 32'h23FC, 32'hA5A5A5A5, 1'b0, 32'hCAFEF00D};
      vecs[5]  = '{"wr_2400_oor",1'b0, 1'b1, 32'h2400, 32'hFFFFFFFF, 1'b1, 32'hCAFEF00D};
      vecs[6]  = '{"rd_23fc",    1'b1, 1'b0, 32'h23FC, 32'h0,        1'b0, 32'hA5A5A5A5};
      vecs[7]  = '{"rd_2000",    1'b1, 1'b0, 32'h2000, 32'h0,        1'b0, 32'h0BADBEEF};
      vecs[8]  = '{"rd_below",   1'b1, 1'b0, 32'h1FFC, 32'h0,        1'b1, 32'h0BADBEEF};
      vecs[9]  = '{"wr_2008",    1'b0, 1'b1, 32'h2008, 32'h11111111, 1'b0, 32'h0BADBEEF};
      vecs[10] = '{"rdwr_2008",  1'b1, 1'b1, 32'h2008, 32'h77777777, 1'b1, 32'h0BADBEEF};
      vecs[11] = '{"rd_2008",    1'b1, 1'b0, 32'h2008, 32'h0,        1'b0, 32'h11111111};

      #12;
      check("reset_ready", 32'(mem_ready), 32'd0);
      check("reset_err", 32'(mem_err), 32'd0);
      check("reset_rdata", mem_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // reset while waiting: pending write dropped, no ready pulse
      @(negedge clk);
      mem_wr = 1'b1;
      mem_addr = 32'h2008;
      mem_wdata = 32'h12345678;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midreset_ready", 32'(mem_ready), 32'd0);
      check("midreset_err", 32'(mem_err), 32'd0);
      check("midreset_rdata", mem_rdata, 32'h0);
      mem_wr = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         seen |= mem_ready;
      end
      check("midreset_no_ready", 32'(seen), 32'd0);
      run_txn('{"rd_2008_after_reset", 1'b1, 1'b0, 32'h2008, 32'h0, 1'b0, 32'h11111111});

      // read held across ready: re-accepted on the IDLE edge
      @(negedge clk);
      mem_rd = 1'b1;
      mem_addr = 32'h2004;
      sb.push_back('{"held_rd1", 1'b0, 32'hCAFEF00D});
      sb.push_back('{"held_rd2", 1'b0, 32'hCAFEF00D});
      @(posedge clk);
      wait_ready(n);
      check("held_latency1", 32'(n), 32'd3);
      pop_check();
      n2 = 0;
      prev = 1'b1;
      consec = 1'b0;
      do begin
         @(posedge clk);
         n2++;
         #1;
         if (mem_ready && prev) consec = 1'b1;
         prev = mem_ready;
      end while (!mem_ready && n2 < 20);
      mem_rd = 1'b0;
      check("held_spacing", 32'(n2), 32'd5);
      check("held_no_consecutive", 32'(consec), 32'd0);
      pop_check();
      @(posedge clk);
      #1;
      check("held_ready_fall", 32'(mem_ready), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         seen |= mem_ready;
      end
      check("held_no_third", 32'(seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
